cordic_iq_phase_detector: RTL and testbench

Iterative vectoring-mode CORDIC that converts one signed I/Q sample pair (cos, sin) into magnitude and phase. It is the receive-side counterpart of the CORDIC I/Q oscillator: it accepts samples in the oscillator's output format and returns the phase in the same angle encoding the oscillator accumulates. Each sample takes one CORDIC micro-rotation per clock, and a valid/ready input handshake throttles the source.

---
 rtl/cordic_iq_phase_detector.sv | 150 +++++++++++++++
 tb/tb_cordic_iq_phase_detector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iq_phase_detector.sv
// Iterative vectoring-mode CORDIC: one signed I/Q pair in, magnitude (gain K, uncompensated)
// and phase out, one micro-rotation per clock behind a valid/ready input handshake.
module cordic_iq_phase_detector #(
    parameter int INT_DATA_WIDTH  = 20,
    parameter int INT_ANGLE_WIDTH = 32,
    parameter int ITERATIONS_CNT  = 30
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic signed [INT_DATA_WIDTH:0] i_cos,
    input  logic signed [INT_DATA_WIDTH:0] i_sin,
    output logic                          o_valid,
    output logic [INT_DATA_WIDTH+1:0]     o_magnitude,
    output logic [INT_ANGLE_WIDTH-1:0]    o_phase
);
    // Fraction bits below the integer LSB keep truncation error out of the phase result.
    localparam int GUARD_BITS = 12;
    localparam int XW         = INT_DATA_WIDTH + 3 + GUARD_BITS;
    localparam int CNT_W      = $clog2(ITERATIONS_CNT + 1);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

    state_t r_state, w_state_next;

    // round(atan(2^-i) / (2*pi) * 2^INT_ANGLE_WIDTH), derived from a 32-bit reference table.
    function automatic logic [INT_ANGLE_WIDTH-1:0] atan_lut(input int i);
        logic [31:0] a;
        logic [63:0] v;
        case (i)
            0:  a = 32'h20000000;  1:  a = 32'h12E4051E;  2:  a = 32'h09FB385B;
            3:  a = 32'h051111D4;  4:  a = 32'h028B0D43;  5:  a = 32'h0145D7E1;
            6:  a = 32'h00A2F61E;  7:  a = 32'h00517C55;  8:  a = 32'h0028BE53;
            9:  a = 32'h00145F2F;  10: a = 32'h000A2F98;  11: a = 32'h000517CC;
            12: a = 32'h00028BE6;  13: a = 32'h000145F3;  14: a = 32'h0000A2FA;
            15: a = 32'h0000517D;  16: a = 32'h000028BE;  17: a = 32'h0000145F;
            18: a = 32'h00000A30;  19: a = 32'h00000518;  20: a = 32'h0000028C;
            21: a = 32'h00000146;  22: a = 32'h000000A3;  23: a = 32'h00000051;
            24: a = 32'h00000029;  25: a = 32'h00000014;  26: a = 32'h0000000A;
            27: a = 32'h00000005;  28: a = 32'h00000003;  29: a = 32'h00000001;
            30: a = 32'h00000001;  31: a = 32'h00000000;
            default: a = 32'h00000000;
        endcase
        if (i < 32) v = {a, 32'h0};
        else        v = (64'd683565276 << 32) >> i;
        v = v + (64'd1 << (63 - INT_ANGLE_WIDTH));
        return INT_ANGLE_WIDTH'(v >> (64 - INT_ANGLE_WIDTH));
    endfunction

    logic [INT_ANGLE_WIDTH-1:0] w_atan [2**CNT_W];
    for (genvar g = 0; g < 2**CNT_W; g++) begin : g_atan
        assign w_atan[g] = atan_lut(g);
    end

    logic signed [XW-1:0]       r_x, r_y;
    logic [INT_ANGLE_WIDTH-1:0] r_z;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_zero;
    logic [INT_DATA_WIDTH+1:0]  r_mag;
    logic [INT_ANGLE_WIDTH-1:0] r_phase;

    logic signed [XW-1:0]       w_cos_ext, w_sin_ext;
    logic signed [XW-1:0]       w_x_sh, w_y_sh, w_x_next, w_y_next;
    logic [INT_ANGLE_WIDTH-1:0] w_z_next;
    logic                       w_last, w_accept;

    assign w_cos_ext = {{2{i_cos[INT_DATA_WIDTH]}}, i_cos, {GUARD_BITS{1'b0}}};
    assign w_sin_ext = {{2{i_sin[INT_DATA_WIDTH]}}, i_sin, {GUARD_BITS{1'b0}}};
    assign w_x_sh    = r_x >>> r_cnt;
    assign w_y_sh    = r_y >>> r_cnt;
    assign w_last    = (r_cnt == CNT_W'(ITERATIONS_CNT - 1));
    assign w_accept  = i_valid && o_ready;

    always_comb begin
        if (!r_y[XW-1]) begin
            w_x_next = r_x + w_y_sh;
            w_y_next = r_y - w_x_sh;
            w_z_next = r_z + w_atan[r_cnt];
        end else begin
            w_x_next = r_x - w_y_sh;
            w_y_next = r_y + w_x_sh;
            w_z_next = r_z - w_atan[r_cnt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            StIdle: begin
                o_ready = !rst;
                if (i_valid) w_state_next = StIter;
            end
            StIter: begin
                if (w_last) w_state_next = StDone;
            end
            StDone: begin
                o_ready      = !rst;
                o_valid      = 1'b1;
                w_state_next = i_valid ? StIter : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_mag   <= '0;
            r_phase <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_zero <= (i_cos == '0) && (i_sin == '0);
            // Left half-plane: rotate by 180 degrees so the vector lies in CORDIC's range.
            if (i_cos[INT_DATA_WIDTH]) begin
                r_x <= -w_cos_ext;
                r_y <= -w_sin_ext;
                r_z <= INT_ANGLE_WIDTH'(1) << (INT_ANGLE_WIDTH - 1);
            end else begin
                r_x <= w_cos_ext;
                r_y <= w_sin_ext;
                r_z <= '0;
            end
        end else if (r_state == StIter) begin
            r_x   <= w_x_next;
            r_y   <= w_y_next;
            r_z   <= w_z_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_mag   <= r_zero ? '0 : w_x_next[GUARD_BITS +: INT_DATA_WIDTH + 2];
                r_phase <= r_zero ? '0 : w_z_next;
            end
        end
    end

    assign o_magnitude = r_mag;
    assign o_phase     = r_phase;

endmodule

// File: tb/tb_cordic_iq_phase_detector.sv
// Self-checking bench: directed, randomized and oscillator-stream samples checked against a
// real-arithmetic atan2/sqrt reference; also covers reset state and mid-iteration reset.
module tb_cordic_iq_phase_detector;
    localparam int  DW   = 20;
    localparam int  AW   = 32;
    localparam int  N_IT = 30;
    localparam real PI   = 3.14159265358979323846;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  i_valid = 1'b0;
    logic signed [DW:0]    i_cos = '0;
    logic signed [DW:0]    i_sin = '0;
    logic                  o_ready;
    logic                  o_valid;
    logic [DW+1:0]         o_magnitude;
    logic [AW-1:0]         o_phase;

    cordic_iq_phase_detector #(
        .INT_DATA_WIDTH (DW),
        .INT_ANGLE_WIDTH(AW),
        .ITERATIONS_CNT (N_IT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_cos      (i_cos),
        .i_sin      (i_sin),
        .o_valid    (o_valid),
        .o_magnitude(o_magnitude),
        .o_phase    (o_phase)
    );

    always #5 clk = ~clk;

    typedef struct { int c; int s; int cyc; } sample_t;

    sample_t q[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    real     k_gain;
    bit      stream_mode = 1'b0;
    bit      have_acc    = 1'b0;
    bit      have_res    = 1'b0;
    int      last_acc_cyc;
    int      low_cnt = 0;
    longint  last_phase, last_ref;

    function automatic longint ref_phase(input int c, input int s);
        real    a;
        longint p;
        a = $atan2(real'(s), real'(c));
        p = longint'($floor(a / (2.0 * PI) * 4294967296.0 + 0.5));
        if (p < 0) p += 64'sd4294967296;
        if (p >= 64'sd4294967296) p -= 64'sd4294967296;
        return p;
    endfunction

    function automatic longint ref_mag(input int c, input int s);
        return longint'($floor(k_gain * $sqrt(real'(c) * real'(c) + real'(s) * real'(s)) + 0.5));
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol, input bit wrap);
        longint d;
        d = obs - exp;
        if (wrap) begin
            d = d & 64'hFFFFFFFF;
            if (d >= 64'sd2147483648) d -= 64'sd4294967296;
        end
        n_checks++;
        if (d > tol || d < -tol) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (tolerance %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic pick_sample(output int c, output int s);
        do begin
            c = int'($urandom_range(0, 2097151)) - 1048576;
            s = int'($urandom_range(0, 2097151)) - 1048576;
        end while (real'(c) * real'(c) + real'(s) * real'(s) < 274877906944.0);
    endtask

    // One clock: drive inputs at the falling edge, observe just after the rising edge.
    task automatic step(input bit v, input int c, input int s);
        bit      acc;
        sample_t e;
        longint  rp;
        bit      zero;
        i_valid = v;
        i_cos   = c[DW:0];
        i_sin   = s[DW:0];
        #1;
        acc = i_valid && o_ready;
        if (!o_ready) low_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            if (stream_mode && have_acc) begin
                check("acc_spacing", cyc - last_acc_cyc, N_IT + 1, 0, 1'b0);
                check("ready_low_cycles", low_cnt, N_IT, 0, 1'b0);
            end
            have_acc     = 1'b1;
            last_acc_cyc = cyc;
            low_cnt      = 0;
            q.push_back('{c, s, cyc});
        end
        if (o_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 1, 0, 0, 1'b0);
            end else begin
                e    = q.pop_front();
                zero = (e.c == 0) && (e.s == 0);
                rp   = ref_phase(e.c, e.s);
                check("latency", cyc - e.cyc, N_IT, 0, 1'b0);
                check("magnitude", longint'(o_magnitude), ref_mag(e.c, e.s), zero ? 0 : 32, 1'b0);
                check("phase", longint'(o_phase), rp, zero ? 0 : 64, 1'b1);
                if (stream_mode && have_res)
                    check("phase_step", longint'(o_phase) - last_phase, rp - last_ref, 128, 1'b1);
                have_res   = 1'b1;
                last_phase = longint'(o_phase);
                last_ref   = rp;
            end
        end else if (q.size() != 0 && cyc - q[0].cyc >= N_IT) begin
            check("missing_valid", 0, 1, 0, 1'b0);
            void'(q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic run_one(input int c, input int s);
        step(1'b1, c, s);
        repeat (N_IT + 1) step(1'b0, 0, 0);
    endtask

    initial begin
        int     c, s, gap;
        longint ph;
        real    ang;

        k_gain = 1.0;
        for (int i = 0; i < N_IT; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", longint'(o_ready), 0, 0, 1'b0);
        check("rst_valid", longint'(o_valid), 0, 0, 1'b0);
        check("rst_magnitude", longint'(o_magnitude), 0, 0, 1'b0);
        check("rst_phase", longint'(o_phase), 0, 0, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", longint'(o_ready), 1, 0, 1'b0);

        run_one(1048575, 0);
        run_one(0, 1048575);
        run_one(0, -1048575);
        run_one(-1048576, 0);
        run_one(741455, 741455);
        run_one(0, 0);

        // Random samples with random traffic (ignored or back-to-back) while busy.
        for (int k = 0; k < 12; k++) begin
            pick_sample(c, s);
            step(1'b1, c, s);
            gap = int'($urandom_range(0, 3));
            for (int j = 0; j < N_IT + gap; j++) begin
                pick_sample(c, s);
                step(1'($urandom_range(0, 1)), c, s);
            end
        end
        repeat (N_IT + 2) step(1'b0, 0, 0);

        // Oscillator stream (25 MHz tone at 125 MHz) with i_valid held high.
        stream_mode = 1'b1;
        have_acc    = 1'b0;
        have_res    = 1'b0;
        low_cnt     = 0;
        ph          = 0;
        for (int n = 0; n < (N_IT + 1) * 6 + 1; n++) begin
            ang = real'(ph) * 2.0 * PI / 4294967296.0;
            c   = int'($floor(1048575.0 * $cos(ang) + 0.5));
            s   = int'($floor(1048575.0 * $sin(ang) + 0.5));
            step(1'b1, c, s);
            ph = (ph + 64'sd858993459) % 64'sd4294967296;
        end
        repeat (N_IT + 2) step(1'b0, 0, 0);
        stream_mode = 1'b0;

        // Reset during iteration 10: result aborted, outputs cleared.
        step(1'b1, 500000, 300000);
        repeat (10) step(1'b0, 0, 0);
        rst = 1'b1;
        #1;
        check("midrst_valid", longint'(o_valid), 0, 0, 1'b0);
        check("midrst_ready", longint'(o_ready), 0, 0, 1'b0);
        check("midrst_magnitude", longint'(o_magnitude), 0, 0, 1'b0);
        check("midrst_phase", longint'(o_phase), 0, 0, 1'b0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready_release", longint'(o_ready), 1, 0, 1'b0);
        repeat (N_IT + 5) step(1'b0, 0, 0);
        check("post_rst_magnitude", longint'(o_magnitude), 0, 0, 1'b0);
        check("post_rst_phase", longint'(o_phase), 0, 0, 1'b0);
        run_one(-700000, 400000);
        if (q.size() != 0) check("pending_results", q.size(), 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
